// File: rtl/counter_pkg.sv
// Shared constants for the multimode counter: terminal-count mode encodings
// and default widths.
package counter_pkg;

    localparam int CNT_WIDTH_DEF   = 8;
    localparam int PRESC_WIDTH_DEF = 8;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_BOUNCE  = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

endpackage

// File: rtl/tick_prescaler.sv
// Integer prescaler: raises tick for one cycle every div+1 enabled cycles.
module tick_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] div,
    output logic               tick
);

    localparam logic [PRESC_W-1:0] PC_ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] pc_r;
    logic               hit_s;

    // >= rather than == so that lowering div below pc recovers immediately
    assign hit_s = (pc_r >= div);
    assign tick  = ena & en & ~clr & hit_s;

    // Prescaler phase counter; cleared by load, frozen by ena=0 or en=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= '0;
        end else if (ena) begin
            if (clr) begin
                pc_r <= '0;
            end else if (en) begin
                pc_r <= hit_s ? '0 : (pc_r + PC_ONE);
            end else begin
                pc_r <= pc_r;
            end
        end else begin
            pc_r <= pc_r;
        end
    end

endmodule

// File: rtl/multimode_counter.sv
// Up/down counter with programmable limit, synchronous load, prescaler and
// wrap / saturate / bounce / one-shot terminal-count behaviour.
module multimode_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = CNT_WIDTH_DEF,
    parameter int PRESC_W = PRESC_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               cnt_en,
    input  logic               dir,
    input  logic [1:0]         mode,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [WIDTH-1:0]   limit,
    input  logic [PRESC_W-1:0] presc_div,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               dir_out,
    output logic               running
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_r;
    logic             tc_r;
    logic             dir_q_r;
    logic             running_r;

    logic             tick_s;
    logic             up_s;
    logic [WIDTH-1:0] inc_s;
    logic [WIDTH-1:0] dec_s;
    logic [WIDTH-1:0] load_cnt_s;
    logic [WIDTH-1:0] next_count_s;
    logic             next_tc_s;
    logic             next_dir_s;
    logic             next_running_s;

    tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .en    (cnt_en & running_r),
        .clr   (load),
        .div   (presc_div),
        .tick  (tick_s)
    );

    assign up_s       = (mode == MODE_BOUNCE) ? ~dir_q_r : ~dir;
    assign inc_s      = count_r + CNT_ONE;
    assign dec_s      = count_r - CNT_ONE;
    assign load_cnt_s = (load_val > limit) ? limit : load_val;

    assign count   = count_r;
    assign tc      = tc_r;
    assign running = running_r;
    assign dir_out = (mode == MODE_BOUNCE) ? dir_q_r : dir;

    // Step rule applied on a tick, per terminal-count mode
    always_comb begin
        next_count_s   = count_r;
        next_tc_s      = 1'b0;
        next_dir_s     = dir_q_r;
        next_running_s = running_r;
        case (mode)
            MODE_WRAP: begin
                if (up_s) begin
                    if (count_r >= limit) begin
                        next_count_s = '0;
                        next_tc_s    = 1'b1;
                    end else begin
                        next_count_s = inc_s;
                    end
                end else begin
                    if (count_r == '0) begin
                        next_count_s = limit;
                        next_tc_s    = 1'b1;
                    end else begin
                        next_count_s = dec_s;
                    end
                end
            end
            MODE_SAT: begin
                if (up_s) begin
                    if (count_r > limit) begin
                        next_count_s = limit;
                        next_tc_s    = 1'b1;
                    end else if (count_r == limit) begin
                        next_count_s = count_r;
                    end else begin
                        next_count_s = inc_s;
                        next_tc_s    = (inc_s == limit);
                    end
                end else begin
                    if (count_r != '0) begin
                        next_count_s = dec_s;
                        next_tc_s    = (count_r == CNT_ONE);
                    end else begin
                        next_count_s = count_r;
                    end
                end
            end
            MODE_BOUNCE: begin
                // A zero-width range cannot reverse; it just reports every tick
                if (limit == '0) begin
                    next_count_s = '0;
                    next_tc_s    = 1'b1;
                end else if (up_s) begin
                    if (count_r >= limit) begin
                        next_count_s = limit - CNT_ONE;
                        next_dir_s   = 1'b1;
                        next_tc_s    = 1'b1;
                    end else begin
                        next_count_s = inc_s;
                    end
                end else begin
                    if (count_r == '0) begin
                        next_count_s = CNT_ONE;
                        next_dir_s   = 1'b0;
                        next_tc_s    = 1'b1;
                    end else begin
                        next_count_s = dec_s;
                    end
                end
            end
            MODE_ONESHOT: begin
                if (up_s) begin
                    if (count_r >= limit) begin
                        next_count_s   = limit;
                        next_tc_s      = 1'b1;
                        next_running_s = 1'b0;
                    end else begin
                        next_count_s   = inc_s;
                        next_tc_s      = (inc_s == limit);
                        next_running_s = (inc_s != limit);
                    end
                end else begin
                    if (count_r == '0) begin
                        next_count_s   = count_r;
                        next_tc_s      = 1'b1;
                        next_running_s = 1'b0;
                    end else begin
                        next_count_s   = dec_s;
                        next_tc_s      = (count_r == CNT_ONE);
                        next_running_s = (count_r != CNT_ONE);
                    end
                end
            end
            default: begin
                next_count_s = count_r;
            end
        endcase
    end

    // Counter state: load beats tick; ena=0 freezes everything but drops tc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r   <= '0;
            tc_r      <= 1'b0;
            dir_q_r   <= 1'b0;
            running_r <= 1'b1;
        end else if (!ena) begin
            tc_r <= 1'b0;
        end else if (load) begin
            count_r   <= load_cnt_s;
            tc_r      <= 1'b0;
            dir_q_r   <= dir;
            running_r <= 1'b1;
        end else if (tick_s) begin
            count_r   <= next_count_s;
            tc_r      <= next_tc_s;
            dir_q_r   <= next_dir_s;
            running_r <= next_running_s;
        end else begin
            tc_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multimode_counter.sv
// Directed bench for multimode_counter: hand-computed sequences for each mode,
// load priority, asynchronous reset and tile enable.
module tb_multimode_counter;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       cnt_en;
    logic       dir;
    logic [1:0] mode;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] limit;
    logic [7:0] presc_div;
    logic [7:0] count;
    logic       tc;
    logic       dir_out;
    logic       running;

    int n_checks;
    int n_fail;

    multimode_counter #(.WIDTH(8), .PRESC_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cnt_en    (cnt_en),
        .dir       (dir),
        .mode      (mode),
        .load      (load),
        .load_val  (load_val),
        .limit     (limit),
        .presc_div (presc_div),
        .count     (count),
        .tc        (tc),
        .dir_out   (dir_out),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ct(input string tag, input int exp_cnt, input int exp_tc);
        chk($sformatf("%s count", tag), int'(count), exp_cnt);
        chk($sformatf("%s tc", tag), int'(tc), exp_tc);
    endtask

    initial begin
        int wrap_cnt [7];
        int wrap_tc  [7];
        int bnc_cnt  [8];
        int bnc_tc   [8];
        int bnc_dir  [8];
        wrap_cnt = '{1, 2, 3, 4, 5, 0, 1};
        wrap_tc  = '{0, 0, 0, 0, 0, 1, 0};
        bnc_cnt  = '{1, 2, 3, 2, 1, 0, 1, 2};
        bnc_tc   = '{0, 0, 0, 1, 0, 0, 1, 0};
        bnc_dir  = '{0, 0, 0, 1, 1, 1, 0, 0};
        n_checks = 0;
        n_fail   = 0;

        // Reset state
        rst_n = 1'b0; ena = 1'b1; cnt_en = 1'b0; dir = 1'b0; mode = 2'b00;
        load = 1'b0; load_val = 8'd0; limit = 8'd5; presc_div = 8'd0;
        step(); step();
        chk_ct("reset", 0, 0);
        chk("reset running", int'(running), 1);
        chk("reset dir_out", int'(dir_out), 0);
        rst_n = 1'b1;
        step();
        chk("idle count", int'(count), 0);

        // WRAP up, L=5, every cycle
        cnt_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk_ct($sformatf("wrap[%0d]", i), wrap_cnt[i], wrap_tc[i]);
        end

        // WRAP with presc_div=3 and a two-cycle cnt_en gap
        limit = 8'd255; presc_div = 8'd3; load_val = 8'd0; load = 1'b1;
        step();
        chk_ct("presc load", 0, 0);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("presc pre[%0d]", i), int'(count), 0);
        end
        step();
        chk("presc tick1", int'(count), 1);
        cnt_en = 1'b0;
        step(); step();
        chk("presc hold", int'(count), 1);
        cnt_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("presc gap[%0d]", i), int'(count), 1);
        end
        step();
        chk("presc tick2", int'(count), 2);

        // SAT down from 3, then SAT up to L=2
        mode = 2'b01; dir = 1'b1; presc_div = 8'd0; load_val = 8'd3; load = 1'b1;
        step();
        chk_ct("sat load", 3, 0);
        load = 1'b0;
        step(); chk_ct("sat dn 2", 2, 0);
        step(); chk_ct("sat dn 1", 1, 0);
        step(); chk_ct("sat dn 0", 0, 1);
        step(); chk_ct("sat dn hold a", 0, 0);
        step(); chk_ct("sat dn hold b", 0, 0);
        limit = 8'd2; dir = 1'b0;
        step(); chk_ct("sat up 1", 1, 0);
        step(); chk_ct("sat up 2", 2, 1);
        step(); chk_ct("sat up hold", 2, 0);

        // BOUNCE, L=3, from 0
        mode = 2'b10; limit = 8'd3; dir = 1'b0; load_val = 8'd0; load = 1'b1;
        step();
        chk_ct("bnc load", 0, 0);
        chk("bnc load dir", int'(dir_out), 0);
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_ct($sformatf("bnc[%0d]", i), bnc_cnt[i], bnc_tc[i]);
            chk($sformatf("bnc[%0d] dir_out", i), int'(dir_out), bnc_dir[i]);
        end

        // ONESHOT up, L=4
        mode = 2'b11; limit = 8'd4; dir = 1'b0; load_val = 8'd0; load = 1'b1;
        step();
        load = 1'b0;
        step(); chk_ct("os 1", 1, 0);
        step(); chk_ct("os 2", 2, 0);
        step(); chk_ct("os 3", 3, 0);
        step();
        chk_ct("os 4", 4, 1);
        chk("os done running", int'(running), 0);
        for (int i = 0; i < 10; i++) step();
        chk_ct("os frozen", 4, 0);
        chk("os frozen running", int'(running), 0);
        load_val = 8'd9; load = 1'b1;
        step();
        chk_ct("os reload clamp", 4, 0);
        chk("os reload running", int'(running), 1);

        // Load and an active tick in the same cycle
        mode = 2'b00; limit = 8'd9; load_val = 8'd7;
        step();
        chk_ct("load vs tick", 7, 0);
        load = 1'b0;
        step(); chk_ct("wrap9 8", 8, 0);
        step(); chk_ct("wrap9 9", 9, 0);
        step(); chk_ct("wrap9 0", 0, 1);

        // Asynchronous reset between edges
        step(); step();
        chk("pre-reset count", int'(count), 2);
        #3 rst_n = 1'b0;
        #1;
        chk_ct("async reset", 0, 0);
        #2 rst_n = 1'b1;
        step(); chk("post-reset 1", int'(count), 1);
        step(); chk("post-reset 2", int'(count), 2);

        // ena=0 freezes and ignores load
        ena = 1'b0; load_val = 8'd5; load = 1'b1;
        step(); step(); step();
        chk_ct("ena off", 2, 0);
        ena = 1'b1; load = 1'b0;
        step();
        chk_ct("ena on", 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multimode_counter.md
Name: multimode_counter

Overview:
Parametrised successor to the team's simple tile counter. Provides up/down counting with a programmable top limit, synchronous load, an integer prescaler and four terminal-count modes: wrap, saturate, bounce and one-shot. Instantiated inside the tt_um top wrapper, with control and status mapped onto ui_in, uio_in and uo_out by the wrapper.

Parameters:
WIDTH, 8, counter width in bits.
PRESC_W, 8, prescaler divider width in bits.

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  tile enable; 0 freezes all state
cnt_en  input  1  count enable; gates the prescaler
dir  input  1  0 = up, 1 = down (initial direction for bounce)
mode  input  2  00 WRAP, 01 SAT, 10 BOUNCE, 11 ONESHOT
load  input  1  synchronous load strobe
load_val  input  WIDTH  value loaded on load
limit  input  WIDTH  top value L; the counting range is 0..L
presc_div  input  PRESC_W  prescaler divide; a tick occurs every presc_div+1 enabled cycles
count  output  WIDTH  current count
tc  output  1  terminal-count pulse, one clk wide, registered
dir_out  output  1  effective direction
running  output  1  0 once ONESHOT has completed

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: count=0, prescaler pc=0, tc=0, internal dir_q=0, running=1, dir_out=dir.
- ena=0: all registers hold, tc forced 0 next cycle, load ignored.
- Prescaler:
  - pc increments while cnt_en=1 and running=1.
  - When pc==presc_div: tick=1 that cycle, pc then goes to 0.
  - presc_div=0 gives a tick every cycle.
  - cnt_en=0 holds pc.
- Load:
  - Has priority over tick.
  - count <= min(load_val, L); pc <= 0; dir_q <= dir; running <= 1; tc <= 0.
- Step rule on a tick, with U = effective direction up and the terminal value T = L (up) or 0 (down):
  - WRAP: up at count>=L goes to 0 with tc=1; down at 0 goes to L with tc=1; otherwise +/-1.
  - SAT: step toward T; tc=1 only on the tick where count becomes T. Further ticks at T hold with tc=0. Up with count>L clamps to L with tc=1.
  - BOUNCE: uses dir_q. Up at count>=L: count <= L-1, dir_q <= 1, tc=1. Down at 0: count <= 1, dir_q <= 0, tc=1. With L==0, count stays 0 and tc=1 on each tick.
  - ONESHOT: steps toward T. On the tick where count becomes T: tc=1, running <= 0. Afterwards pc and count freeze until load.
- dir_out = dir_q in BOUNCE, dir otherwise.
- Latency: count and tc update on the clk edge ending the tick cycle; tc is high exactly the following cycle.
- Arithmetic: unsigned, modulo 2^WIDTH internally. Comparisons are unsigned against limit.
- Mode, dir or limit changes take effect at the next tick. Changing mode does not clear running; only load or reset restarts a one-shot.
- Reset asserted mid-count: outputs return to reset values immediately, without waiting for clk.

Decomposition:
- Package counter_pkg:
  - mode localparams MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_BOUNCE=2'b10, MODE_ONESHOT=2'b11
  - default WIDTH and PRESC_W constants
- One sub-module, tick_prescaler (PRESC_W; clk, rst_n, ena, en, clr, div -> tick). The clr input is driven by load.
- Next-count logic stays in multimode_counter.

Test Plan:
- Reset then WRAP up, L=5, presc_div=0, cnt_en=1 -> count 0,1,2,3,4,5,0. tc=1 only in the cycle after 5->0.
- presc_div=3, WRAP up, L=255 -> count increments every 4th cycle. Assert cnt_en=0 for 2 cycles -> tick is delayed by 2 cycles.
- SAT down, load_val=3 -> count 3,2,1,0,0,0. tc pulses once, on 1->0. Then set limit=2, dir=0 -> 0,1,2,2 with tc on 1->2.
- BOUNCE, L=3, start at 0 -> count 0,1,2,3,2,1,0,1. tc after 3->2 and after 0->1 reversals; dir_out toggles accordingly.
- ONESHOT up, L=4 -> count reaches 4, tc=1 once, running=0, count holds over 10 ticks. Load with load_val=9 -> count=4 (clamped), running=1.
- Load and tick in the same cycle (load_val=7) -> count=7, tc=0. Assert rst_n=0 asynchronously between edges -> count=0 and tc=0 immediately. ena=0 -> count frozen.
